// File: rtl/i2s_stereo_transceiver.sv
// I2S master: BCLK/LRCLK generation, stereo TX from a one-deep holding register, stereo RX; I2S_LEFT_JUSTIFIED_EN selects left-justified framing.
// Latency: a sample accepted in frame N is transmitted in frame N+1; rx_valid pulses one clk after the right-slot last bit is sampled.
// Backpressure: tx_ready drops while the holding register is full; RX has none, so the consumer must take every rx_valid pulse.
module i2s_stereo_transceiver #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int SAMPLE_RATE  = 44_100,
    parameter int DATA_WIDTH   = 16,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    input  logic                  i2s_sdata_in,
    output logic                  i2s_sdata_out
);

    localparam int HALF_DIV_RAW = SYS_CLK_FREQ / (SAMPLE_RATE * 4 * SLOT_WIDTH);
    localparam int HALF_DIV     = (HALF_DIV_RAW < 1) ? 1 : HALF_DIV_RAW;
    localparam int DIV_W        = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int CNT_W        = $clog2(2 * SLOT_WIDTH);
    localparam int DW           = DATA_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [CNT_W-1:0] SLOT     = CNT_W'(SLOT_WIDTH);

`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DATA_WIDTH - 1);
    if (DATA_WIDTH > SLOT_WIDTH) begin : g_width_chk
        $error("DATA_WIDTH must not exceed SLOT_WIDTH");
    end
`else
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DATA_WIDTH);
    if (DATA_WIDTH >= SLOT_WIDTH) begin : g_width_chk
        $error("DATA_WIDTH must be smaller than SLOT_WIDTH");
    end
`endif
    if (DATA_WIDTH < 2) begin : g_dw_chk
        $error("DATA_WIDTH must be at least 2");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             hold_full_q, hold_full_d;
    logic [DW-1:0]    hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DW-1:0]    tx_l_sh_q, tx_l_sh_d, tx_r_sh_q, tx_r_sh_d;
    logic [DW-1:0]    rx_l_sh_q, rx_l_sh_d, rx_r_sh_q, rx_r_sh_d;
    logic [DW-1:0]    rx_left_q, rx_left_d, rx_right_q, rx_right_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;

    logic             toggle, fall_tick, rise_tick, frame_start;
    logic [CNT_W-1:0] cnt_nxt, tx_pos, rx_pos;
    logic             tx_in_data, rx_in_data;
    logic [DW-1:0]    cur_l, cur_r;

    always_comb begin
        div_d       = div_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        bit_cnt_d   = bit_cnt_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        tx_l_sh_d   = tx_l_sh_q;
        tx_r_sh_d   = tx_r_sh_q;
        rx_l_sh_d   = rx_l_sh_q;
        rx_r_sh_d   = rx_r_sh_q;
        rx_left_d   = rx_left_q;
        rx_right_d  = rx_right_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        cur_l       = tx_l_sh_q;
        cur_r       = tx_r_sh_q;

        toggle      = (div_q == DIV_LAST);
        fall_tick   = toggle && bclk_q;
        rise_tick   = toggle && !bclk_q;
        frame_start = fall_tick && (bit_cnt_q == CNT_LAST);
        cnt_nxt     = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
        tx_pos      = (cnt_nxt >= SLOT) ? cnt_nxt - SLOT : cnt_nxt;
        rx_pos      = (bit_cnt_q >= SLOT) ? bit_cnt_q - SLOT : bit_cnt_q;
`ifdef I2S_LEFT_JUSTIFIED_EN
        tx_in_data  = (tx_pos <= P_LAST);
        rx_in_data  = (rx_pos <= P_LAST);
`else
        tx_in_data  = (tx_pos != '0) && (tx_pos <= P_LAST);
        rx_in_data  = (rx_pos != '0) && (rx_pos <= P_LAST);
`endif

        if (toggle) begin
            div_d  = '0;
            bclk_d = !bclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end

        // accept and frame-start load are exclusive: one needs empty, the other full
        if (tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_l_d    = tx_left;
            hold_r_d    = tx_right;
        end

        if (fall_tick) begin
            bit_cnt_d = cnt_nxt;
            if (frame_start) begin
                lrclk_d    = 1'b0;
                underrun_d = !hold_full_q;
                if (hold_full_q) begin
                    cur_l       = hold_l_q;
                    cur_r       = hold_r_q;
                    hold_full_d = 1'b0;
                end else begin
                    cur_l = '0;
                    cur_r = '0;
                end
            end
            if (cnt_nxt == SLOT) begin
                lrclk_d = 1'b1;
            end
            sdata_d   = 1'b0;
            tx_l_sh_d = cur_l;
            tx_r_sh_d = cur_r;
            if (tx_in_data) begin
                if (cnt_nxt < SLOT) begin
                    sdata_d   = cur_l[DW-1];
                    tx_l_sh_d = {cur_l[DW-2:0], 1'b0};
                end else begin
                    sdata_d   = cur_r[DW-1];
                    tx_r_sh_d = {cur_r[DW-2:0], 1'b0};
                end
            end
        end

        if (rise_tick && rx_in_data) begin
            if (bit_cnt_q < SLOT) begin
                rx_l_sh_d = {rx_l_sh_q[DW-2:0], i2s_sdata_in};
            end else begin
                rx_r_sh_d = {rx_r_sh_q[DW-2:0], i2s_sdata_in};
                if (rx_pos == P_LAST) begin
                    rx_left_d  = rx_l_sh_q;
                    rx_right_d = {rx_r_sh_q[DW-2:0], i2s_sdata_in};
                    rx_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b1;
            sdata_q     <= 1'b0;
            bit_cnt_q   <= CNT_LAST;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            tx_l_sh_q   <= '0;
            tx_r_sh_q   <= '0;
            rx_l_sh_q   <= '0;
            rx_r_sh_q   <= '0;
            rx_left_q   <= '0;
            rx_right_q  <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            tx_l_sh_q   <= tx_l_sh_d;
            tx_r_sh_q   <= tx_r_sh_d;
            rx_l_sh_q   <= rx_l_sh_d;
            rx_r_sh_q   <= rx_r_sh_d;
            rx_left_q   <= rx_left_d;
            rx_right_q  <= rx_right_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign tx_ready      = !hold_full_q;
    assign tx_underrun   = underrun_q;
    assign rx_left       = rx_left_q;
    assign rx_right      = rx_right_q;
    assign rx_valid      = rx_valid_q;
    assign i2s_bclk      = bclk_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_sdata_out = sdata_q;

endmodule
